l1_loss_grad: RTL and testbench
===============================

// Module: l1_loss_grad
// PURPOSE
//  Backward-pass partner of the L1 loss block: computes dL/dp = scale*sign(p - t) per class, with t the one-hot target in fp32.
//  Snapshots FC-layer probabilities plus one-hot label on start; streams one fp32 gradient per beat (valid/ready) into FC backprop.
// PARAMETERS
//  FC_OUTPUT_SIZE  10                        number of classes / gradient beats per run (>=2)
//  IDX_W           $clog2(FC_OUTPUT_SIZE)    width of grad_idx
// PORTS
//  clk              in   1        single clock, rising edge
//  rst_n            in   1        reset, asynchronous, active-low
//  start            in   1        run request, sampled only in IDLE
//  predicted_probs  in   32xN     fp32 predictions [0:FC_OUTPUT_SIZE-1]
//  ground_truth     in   N        one-hot label, bit i = class i
//  grad_scale       in   32       fp32 magnitude (only with L1_GRAD_SCALE_EN)
//  grad_data        out  32       fp32 gradient for class grad_idx
//  grad_idx         out  IDX_W    class index of current beat
//  grad_valid       out  1        beat valid
//  grad_ready       in   1        downstream accepts beat
//  grad_last        out  1        high with final beat (idx N-1)
//  busy             out  1        high in PREP/EMIT/DONE
//  done             out  1        one-cycle pulse after last beat accepted
//  onehot_err       out  1        label popcount != 1 at snapshot; held until next start
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; grad_data=0, grad_idx=0, grad_valid=0, grad_last=0, busy=0, done=0, onehot_err=0.
//  FSM: IDLE -start-> PREP -> EMIT -(accept of idx N-1)-> DONE -> IDLE.
//   IDLE: on start, snapshot predicted_probs/ground_truth (and grad_scale) into regs; compute onehot_err; ->PREP.
//   PREP: register grad for idx 0; grad_valid rises entering EMIT => first beat valid 2 cycles after start edge.
//   EMIT: beat accepted when grad_valid&&grad_ready. Non-last: idx++, grad_data<=grad(idx+1) same edge (1 beat/clk
//     back-to-back). Last: grad_valid<=0 ->DONE. While grad_ready low, data/idx/last held stable.
//   DONE: done=1 for exactly one cycle, busy stays high; ->IDLE. New start accepted the cycle after DONE.
//  start outside IDLE ignored; input changes after snapshot have no effect on the run in flight.
//  Gradient rule, c = fp32_cmp(p_i, t_i) with t_i = ground_truth[i] ? 1.0 (0x3F800000) : +0.0:
//   c=+1 -> +MAG; c=-1 -> -MAG (sign bit set); c=0 -> 0x00000000. +0 and -0 compare equal.
//   p_i NaN (exp=0xFF, mant!=0) -> 0x00000000. +/-Inf compares as ordered extreme. Denormals compare by bits.
//  fp32_cmp: sign-magnitude ordering done in integer compare; no FP subtraction anywhere.
//  Multiple/zero label bits: each bit still used as its own target; onehot_err set for that run only.
//  rst_n asserted mid-run: immediate abort to reset values, no done pulse; partial stream discarded downstream.
// CONFIGURATION
//  L1_GRAD_SCALE_EN defined: grad_scale port exists, snapshotted at start; MAG = {1'b0, grad_scale[30:0]} (sign of
//   grad_scale ignored); used for mean reduction / learning-rate folding.
//  Not defined: no grad_scale port; MAG = 0x3F800000 (1.0).
// STRUCTURE
//  Package l1_loss_pkg: FP32_ONE=32'h3F800000, FP32_NEG_ONE=32'hBF800000, FP32_ZERO=32'h0, FP32_EXP_NAN=8'hFF,
//   typedef enum {CMP_LT, CMP_EQ, CMP_GT} cmp_t, FSM state enum l1g_state_t {IDLE, PREP, EMIT, DONE}.
//  Sub-module fp32_sign_cmp (combinational: a, b -> cmp_t, is_nan); one instance on mux-selected snapshot[idx].
// TESTING
//  1 N=10, label bit3, p all 0x3E000000 (0.125), ready=1 -> 10 beats consecutive clks: idx3=0xBF800000, others
//    0x3F800000; grad_last on idx9; done pulse 1 cycle after; first valid 2 clks after start.
//  2 p[3]=0x3F800000, p[5]=0x00000000, p[7]=0x80000000, label bit3 -> idx3,5,7 all 0x00000000.
//  3 ready toggled 1010.., then low 5 clks mid-stream -> grad_data/idx stable while stalled; exactly 10 beats; order
//    0..9 preserved.
//  4 label=0 then label=0x009 -> onehot_err=1 both runs; beats still per-bit rule; next run with one-hot -> onehot_err=0.
//  5 rst_n low at beat 4 -> all outputs 0 asynchronously, no done; start after release -> full clean 10-beat run.
//  6 p[0]=0x7FC00000 (NaN) -> 0x0; with L1_GRAD_SCALE_EN, grad_scale=0xBDCCCCCD, p=0.125, label bit0 ->
//    idx0=0xBDCCCCCD, idx1..9=0x3DCCCCCD; start pulsed during EMIT -> ignored.

Source files
------------

// File: rtl/l1_loss_pkg.sv
// l1_loss_pkg: shared fp32 constants, compare result and FSM state types for l1_loss_grad.
package l1_loss_pkg;
  localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP32_NEG_ONE = 32'hBF80_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
  localparam logic [7:0]  FP32_EXP_NAN = 8'hFF;
  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_t;
  typedef enum logic [1:0] {IDLE, PREP, EMIT, DONE} l1g_state_t;
endpackage

// File: rtl/fp32_sign_cmp.sv
// fp32_sign_cmp: orders two fp32 values with integer sign-magnitude compares; flags a as NaN.
module fp32_sign_cmp
  import l1_loss_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output cmp_t        cmp,
  output logic        is_nan
);
  logic both_zero, mag_eq, mag_gt;
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
  assign mag_eq    = a[30:0] == b[30:0];
  assign mag_gt    = a[30:0] > b[30:0];
  // Both negative: the larger magnitude is the smaller value.
  assign cmp = both_zero ? CMP_EQ :
               (a[31] != b[31]) ? (a[31] ? CMP_LT : CMP_GT) :
               mag_eq ? CMP_EQ :
               (mag_gt ^ a[31]) ? CMP_GT : CMP_LT;
  assign is_nan = (a[30:23] == FP32_EXP_NAN) && (a[22:0] != 23'd0);
endmodule

// File: rtl/l1_loss_grad.sv
// l1_loss_grad: streams dL/dp = MAG*sign(p - onehot) per class over valid/ready.
// Define L1_GRAD_SCALE_EN to add grad_scale (magnitude snapshotted at start); otherwise MAG = 1.0.
module l1_loss_grad
  import l1_loss_pkg::*;
#(
  parameter int FC_OUTPUT_SIZE = 10,
  parameter int IDX_W          = $clog2(FC_OUTPUT_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [32*FC_OUTPUT_SIZE-1:0] predicted_probs,
  input  logic [FC_OUTPUT_SIZE-1:0]    ground_truth,
`ifdef L1_GRAD_SCALE_EN
  input  logic [31:0]                  grad_scale,
`endif
  output logic [31:0]                  grad_data,
  output logic [IDX_W-1:0]             grad_idx,
  output logic                         grad_valid,
  input  logic                         grad_ready,
  output logic                         grad_last,
  output logic                         busy,
  output logic                         done,
  output logic                         onehot_err
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FC_OUTPUT_SIZE - 1);
  l1g_state_t state_q, state_d;
  logic [FC_OUTPUT_SIZE-1:0][31:0] probs_q, probs_d;
  logic [FC_OUTPUT_SIZE-1:0] label_q, label_d;
  logic [IDX_W-1:0] idx_q, idx_d, sel;
  logic [31:0] data_q, data_d, grad;
  logic [30:0] mag;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, err_q, err_d;
  cmp_t cmp;
  logic is_nan;
`ifdef L1_GRAD_SCALE_EN
  logic [30:0] scale_q, scale_d;
  assign mag = scale_q;
`else
  assign mag = FP32_ONE[30:0];
`endif
  // PREP computes beat 0; EMIT precomputes the next beat so accepts run back-to-back.
  assign sel = (state_q == EMIT && idx_q != LAST_IDX) ? idx_q + IDX_W'(1) : '0;
  fp32_sign_cmp u_cmp (
    .a      (probs_q[sel]),
    .b      (label_q[sel] ? FP32_ONE : FP32_ZERO),
    .cmp    (cmp),
    .is_nan (is_nan)
  );
  assign grad = is_nan ? FP32_ZERO :
                cmp == CMP_GT ? {1'b0, mag} :
                cmp == CMP_LT ? {1'b1, mag} : FP32_ZERO;
  always_comb begin
    state_d = state_q;
    probs_d = probs_q;
    label_d = label_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef L1_GRAD_SCALE_EN
    scale_d = scale_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        probs_d = predicted_probs;
        label_d = ground_truth;
        err_d   = $countones(ground_truth) != 1;
`ifdef L1_GRAD_SCALE_EN
        scale_d = grad_scale[30:0];
`endif
        state_d = PREP;
      end
      PREP: begin
        idx_d   = '0;
        data_d  = grad;
        valid_d = 1'b1;
        last_d  = 1'b0;
        state_d = EMIT;
      end
      EMIT: if (valid_q && grad_ready) begin
        if (last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          data_d = grad;
          last_d = (idx_q + IDX_W'(1)) == LAST_IDX;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      probs_q <= '0;
      label_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef L1_GRAD_SCALE_EN
      scale_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      probs_q <= probs_d;
      label_q <= label_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef L1_GRAD_SCALE_EN
      scale_q <= scale_d;
`endif
    end
  end
  assign grad_data  = data_q;
  assign grad_idx   = idx_q;
  assign grad_valid = valid_q;
  assign grad_last  = last_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign onehot_err = err_q;
endmodule

// File: tb/tb_l1_loss_grad.sv
// tb_l1_loss_grad: directed tests for l1_loss_grad; scale test runs when L1_GRAD_SCALE_EN is defined.
module tb_l1_loss_grad;
  localparam int N  = 10;
  localparam int IW = $clog2(N);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, grad_ready = 1'b0;
  logic [32*N-1:0] predicted_probs = '0;
  logic [N-1:0] ground_truth = '0;
`ifdef L1_GRAD_SCALE_EN
  logic [31:0] grad_scale = 32'h3F80_0000;
`endif
  logic [31:0] grad_data;
  logic [IW-1:0] grad_idx;
  logic grad_valid, grad_last, busy, done, onehot_err;
  always #5 clk = ~clk;
  l1_loss_grad #(.FC_OUTPUT_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .predicted_probs(predicted_probs), .ground_truth(ground_truth),
`ifdef L1_GRAD_SCALE_EN
    .grad_scale(grad_scale),
`endif
    .grad_data(grad_data), .grad_idx(grad_idx), .grad_valid(grad_valid),
    .grad_ready(grad_ready), .grad_last(grad_last), .busy(busy),
    .done(done), .onehot_err(onehot_err)
  );
  int n_checks = 0, n_fail = 0;
  logic [31:0] b_data[16];
  logic [IW-1:0] b_idx[16];
  logic b_last[16];
  logic [31:0] expv[N];
  int nb, lat, done_at, dones, stall_bad;
  bit tmo;
  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < N; i++) predicted_probs[32*i +: 32] = v;
  endtask
  // Pulse start, then per negedge: drive ready, record accepted beats, watch stalls and done.
  task automatic run(input logic [63:0] rmask, input int spulse, input bit scramble);
    logic [31:0] pd;
    logic [IW-1:0] pi;
    bit pstall;
    nb = 0; lat = -1; done_at = -1; dones = 0; stall_bad = 0; tmo = 1'b1;
    pstall = 1'b0; pd = '0; pi = '0;
    for (int i = 0; i < 16; i++) begin b_data[i] = 'x; b_idx[i] = 'x; b_last[i] = 1'bx; end
    @(negedge clk);
    start = 1'b1;
    grad_ready = rmask[0];
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      start = (c == spulse);
      if (scramble && c == 1) begin
        set_all(32'h7FC0_0000);
        ground_truth = ~ground_truth;
      end
      grad_ready = (c < 64) ? rmask[c] : 1'b1;
      if (grad_valid && lat < 0) lat = c;
      if (pstall && (grad_data !== pd || grad_idx !== pi)) stall_bad++;
      if (done) begin dones++; if (done_at < 0) done_at = c; end
      if (grad_valid && grad_ready && nb < 16) begin
        b_data[nb] = grad_data; b_idx[nb] = grad_idx; b_last[nb] = grad_last; nb++;
      end
      pstall = grad_valid && !grad_ready;
      pd = grad_data;
      pi = grad_idx;
      if (done_at >= 0 && c >= done_at + 2) begin tmo = 1'b0; break; end
    end
    start = 1'b0;
    grad_ready = 1'b0;
  endtask
  task automatic check_stream(input string name);
    n_checks++;
    if (tmo !== 1'b0 || nb !== N) begin
      n_fail++; $display("FAIL %s_beats got %0d (timeout=%0b) exp %0d", name, nb, tmo, N);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (b_data[i] !== expv[i] || b_idx[i] !== IW'(i) || b_last[i] !== (i == N - 1)) begin
        n_fail++;
        $display("FAIL %s_beat%0d got %h/%0d/%b exp %h/%0d/%b", name, i,
                 b_data[i], b_idx[i], b_last[i], expv[i], i, (i == N - 1));
      end
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL %s_done_pulses got %0d exp 1", name, dones); end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({grad_data, grad_idx, grad_valid, grad_last, busy, done, onehot_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h/%0d/%b%b%b%b%b exp all 0",
                         grad_data, grad_idx, grad_valid, grad_last, busy, done, onehot_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || grad_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle got busy=%b valid=%b exp 0 0", busy, grad_valid);
    end
  endtask
  task automatic test_basic();
    set_all(32'h3E00_0000);
    ground_truth = 10'b00_0000_1000;
    for (int i = 0; i < N; i++) expv[i] = (i == 3) ? 32'hBF80_0000 : 32'h3F80_0000;
    run('1, 0, 1'b0);
    check_stream("basic");
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL basic_first_valid got %0d exp 2", lat); end
    n_checks++;
    if (done_at !== 12) begin n_fail++; $display("FAIL basic_done_cycle got %0d exp 12", done_at); end
    n_checks++;
    if (busy !== 1'b0 || onehot_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_end got busy=%b err=%b exp 0 0", busy, onehot_err);
    end
  endtask
  task automatic test_compare_edges();
    logic [31:0] pv[N];
    pv = '{32'h3E00_0000, 32'hBF00_0000, 32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000,
           32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'h3F80_0001, 32'h3F7F_FFFF};
    expv = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h0, 32'hBF80_0000,
             32'h0, 32'h3F80_0000, 32'h0, 32'h3F80_0000, 32'h3F80_0000};
    for (int i = 0; i < N; i++) predicted_probs[32*i +: 32] = pv[i];
    ground_truth = 10'b00_0000_1000;
    run('1, 0, 1'b0);
    check_stream("cmp");
  endtask
  task automatic test_backpressure();
    logic [63:0] m;
    for (int c = 0; c < 64; c++) m[c] = (c % 2 == 0) && !(c >= 10 && c <= 14);
    set_all(32'h3E00_0000);
    ground_truth = 10'b00_0000_1000;
    for (int i = 0; i < N; i++) expv[i] = (i == 3) ? 32'hBF80_0000 : 32'h3F80_0000;
    run(m, 0, 1'b0);
    check_stream("bp");
    n_checks++;
    if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d changes exp 0", stall_bad); end
  endtask
  task automatic test_onehot_err();
    set_all(32'h3E00_0000);
    ground_truth = '0;
    for (int i = 0; i < N; i++) expv[i] = 32'h3F80_0000;
    run('1, 0, 1'b0);
    check_stream("lbl0");
    n_checks++;
    if (onehot_err !== 1'b1) begin n_fail++; $display("FAIL lbl0_err got %b exp 1", onehot_err); end
    ground_truth = 10'h009;
    for (int i = 0; i < N; i++) expv[i] = (i == 0 || i == 3) ? 32'hBF80_0000 : 32'h3F80_0000;
    run('1, 0, 1'b0);
    check_stream("lbl9");
    n_checks++;
    if (onehot_err !== 1'b1) begin n_fail++; $display("FAIL lbl9_err got %b exp 1", onehot_err); end
    ground_truth = 10'b10_0000_0000;
    for (int i = 0; i < N; i++) expv[i] = (i == 9) ? 32'hBF80_0000 : 32'h3F80_0000;
    run('1, 0, 1'b0);
    check_stream("lbl1h");
    n_checks++;
    if (onehot_err !== 1'b0) begin n_fail++; $display("FAIL lbl1h_err got %b exp 0", onehot_err); end
  endtask
  task automatic test_reset_mid();
    int seen;
    set_all(32'h3E00_0000);
    ground_truth = 10'b00_0000_1000;
    @(negedge clk);
    start = 1'b1;
    grad_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !(grad_valid && grad_idx == IW'(4)); c++) @(negedge clk);
    n_checks++;
    if (!(grad_valid && grad_idx == IW'(4))) begin
      n_fail++; $display("FAIL rstmid_reach4 got valid=%b idx=%0d exp 1 4", grad_valid, grad_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grad_data, grad_idx, grad_valid, grad_last, busy, done, onehot_err} !== '0) begin
      n_fail++; $display("FAIL rstmid_async got %h/%0d/%b%b%b%b%b exp all 0",
                         grad_data, grad_idx, grad_valid, grad_last, busy, done, onehot_err);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); if (done) seen++; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d pulses exp 0", seen); end
    grad_ready = 1'b0;
    for (int i = 0; i < N; i++) expv[i] = (i == 3) ? 32'hBF80_0000 : 32'h3F80_0000;
    run('1, 0, 1'b0);
    check_stream("rstmid_rerun");
  endtask
  task automatic test_nan_ignore();
    set_all(32'h3E00_0000);
    predicted_probs[31:0] = 32'h7FC0_0000;
    ground_truth = 10'b00_0000_0001;
    expv[0] = 32'h0;
    for (int i = 1; i < N; i++) expv[i] = 32'h3F80_0000;
    run('1, 5, 1'b1);
    check_stream("nan");
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || grad_valid !== 1'b0) begin
      n_fail++; $display("FAIL nan_start_ignored got busy=%b valid=%b exp 0 0", busy, grad_valid);
    end
  endtask
`ifdef L1_GRAD_SCALE_EN
  task automatic test_scale();
    set_all(32'h3E00_0000);
    ground_truth = 10'b00_0000_0001;
    grad_scale = 32'hBDCC_CCCD;
    expv[0] = 32'hBDCC_CCCD;
    for (int i = 1; i < N; i++) expv[i] = 32'h3DCC_CCCD;
    run('1, 0, 1'b0);
    check_stream("scale");
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_compare_edges();
    test_backpressure();
    test_onehot_err();
    test_reset_mid();
    test_nan_ignore();
`ifdef L1_GRAD_SCALE_EN
    test_scale();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
